// File: rtl/ctrl_cmd_master_if.sv
// if_axi_light: AXI-lite channel bundle with master and slave views
interface if_axi_light #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ctrl_cmd_master.sv
// ctrl_cmd_master: turns single-beat node commands into one-at-a-time AXI-lite accesses to the control slave
`ifndef NUM_NODES_PROCESSING_WIDTH
`define NUM_NODES_PROCESSING_WIDTH 4
`endif
module ctrl_cmd_master #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] CTRL_BASE      = 32'h8000_0000,
  parameter int                        NODE_W         = `NUM_NODES_PROCESSING_WIDTH,
  parameter int                        NODE_LSB       = 2,
  parameter int                        TIMEOUT        = 1024
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [NODE_W-1:0] cmd_node,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
  output logic              timeout_flag,
  if_axi_light.master       m_axi
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
  state_t st, nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q;
  logic [4:0] opbit;
  logic [TW-1:0] timer;
  logic aw_done, w_done, aw_ok, w_ok, accept, is_wr, waiting;
  assign cmd_ready = st == IDLE;
  assign rsp_valid = st == RSP;
  assign busy = st != IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign is_wr = cmd_op == 3'd0 || cmd_op == 3'd6 || cmd_op == 3'd7;
  assign waiting = st inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
  assign aw_ok = aw_done | m_axi.awready;
  assign w_ok = w_done | m_axi.wready;
  assign opbit = cmd_op <= 3'd1 ? 5'd7 : cmd_op == 3'd2 ? 5'd8 : cmd_op == 3'd3 ? 5'd9 :
                 cmd_op == 3'd4 ? 5'd10 : cmd_op == 3'd5 ? 5'd15 : cmd_op == 3'd6 ? 5'd18 : 5'd19;
  assign addr_d = CTRL_BASE | (AXI_ADDR_WIDTH'(1) << (AXI_ADDR_WIDTH - 1)) |
                  (AXI_ADDR_WIDTH'(cmd_node) << NODE_LSB) | (AXI_ADDR_WIDTH'(1) << opbit);
  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = '1;
  assign m_axi.awvalid = st == WR_ADDR_DATA && !aw_done;
  assign m_axi.wvalid = st == WR_ADDR_DATA && !w_done;
  assign m_axi.bready = st == WR_RESP;
  assign m_axi.arvalid = st == RD_ADDR;
  assign m_axi.rready = st == RD_DATA;
  // Next state: each phase advances only on its own handshake, so a stalled slave just holds the state
  always_comb begin
    nxt = st;
    case (st)
      IDLE:         if (cmd_valid) nxt = is_wr ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_ok && w_ok) nxt = WR_RESP;
      WR_RESP:      if (m_axi.bvalid) nxt = RSP;
      RD_ADDR:      if (m_axi.arready) nxt = RD_DATA;
      RD_DATA:      if (m_axi.rvalid) nxt = RSP;
      RSP:          if (rsp_ready) nxt = IDLE;
      default:      nxt = IDLE;
    endcase
  end
  // State, latched command, response capture and the per-phase watchdog
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      st <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      timer <= '0;
      timeout_flag <= 1'b0;
    end else begin
      st <= nxt;
      if (accept) begin
        addr_q <= addr_d;
        wdata_q <= cmd_op == 3'd0 ? cmd_wdata : {24'b0, cmd_wdata[7:0]};
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (st == WR_ADDR_DATA) begin
        aw_done <= aw_ok;
        w_done <= w_ok;
      end
      if (st == WR_RESP && m_axi.bvalid) begin
        rsp_rdata <= '0;
        rsp_resp <= m_axi.bresp;
      end
      if (st == RD_DATA && m_axi.rvalid) begin
        rsp_rdata <= m_axi.rdata;
        rsp_resp <= m_axi.rresp;
      end
      timer <= nxt != st ? '0 : waiting && timer != TW'(TIMEOUT) ? timer + 1'b1 : timer;
      if (waiting && nxt == st && timer == TW'(TIMEOUT - 1)) timeout_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ctrl_cmd_master.sv
// tb_ctrl_cmd_master: vector table plus random traffic against a delay-programmable AXI-lite slave model
module tb_ctrl_cmd_master;
  logic clk = 0, res_n = 0;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, busy, timeout_flag;
  logic [2:0] cmd_op = 0;
  logic [3:0] cmd_node = 0;
  logic [31:0] cmd_wdata = 0, rsp_rdata;
  logic [1:0] rsp_resp;
  int checks = 0, passed = 0, txn = 0;
  if_axi_light axi ();
  ctrl_cmd_master #(.NODE_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .res_n(res_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_node(cmd_node), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout_flag(timeout_flag), .m_axi(axi)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op; logic [3:0] node; logic [31:0] wdata;
    int awd, wd, bd, ard, rd;
    logic [31:0] srdata; logic [1:0] sresp; int hold;
    logic [31:0] e_addr, e_wdata, e_rdata; logic [1:0] e_resp; int e_lat;
  } vec_t;
  int s_awd = 0, s_wd = 0, s_bd = 0, s_ard = 0, s_rd = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0] s_resp = 0;
  int aw_c, w_c, b_c, ar_c, r_c, aw_hi, w_hi, b_n, ar_n, r_n, viol;
  logic aw_got, w_got, wr_pend, rd_pend;
  logic aw_v_s, w_v_s, ar_v_s, b_v_s, b_r_s, r_v_s, r_r_s;
  logic [31:0] aw_a_s, ar_a_s, w_d_s, got_awaddr, got_araddr, got_wdata;
  logic [2:0] aw_p_s, ar_p_s, got_awprot, got_arprot;
  logic [3:0] w_s_s, got_wstrb;
  // Slave: handshakes of the last rising edge are settled at each falling edge, then readies/valids are redriven
  always @(negedge clk) begin
    if (!res_n) begin
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
      aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      aw_v_s = 0; w_v_s = 0; ar_v_s = 0; b_v_s = 0; b_r_s = 0; r_v_s = 0; r_r_s = 0;
    end else begin
      if (b_v_s && b_r_s) begin b_n++; wr_pend = 0; aw_got = 0; w_got = 0; end
      if (r_v_s && r_r_s) begin r_n++; rd_pend = 0; end
      if (aw_v_s && axi.awready) begin
        if (aw_got || rd_pend) viol++;
        aw_got = 1; aw_c = 0; got_awaddr = aw_a_s; got_awprot = aw_p_s;
      end else if (aw_v_s) begin
        aw_c++; if (!axi.awvalid) viol++;
      end
      if (w_v_s && axi.wready) begin
        if (w_got || rd_pend) viol++;
        w_got = 1; w_c = 0; got_wdata = w_d_s; got_wstrb = w_s_s;
      end else if (w_v_s) begin
        w_c++; if (!axi.wvalid) viol++;
      end
      if (ar_v_s && axi.arready) begin
        if (rd_pend || aw_got || w_got) viol++;
        rd_pend = 1; r_c = 0; ar_c = 0; ar_n++; got_araddr = ar_a_s; got_arprot = ar_p_s;
      end else if (ar_v_s) begin
        ar_c++; if (!axi.arvalid) viol++;
      end
      if (aw_got && w_got && !wr_pend) begin wr_pend = 1; b_c = 0; end
      if (axi.bready && !wr_pend) viol++;
      if (axi.rready && !rd_pend) viol++;
      if ((axi.awvalid || axi.wvalid) && axi.arvalid) viol++;
      axi.awready = axi.awvalid && aw_c >= s_awd;
      axi.wready = axi.wvalid && w_c >= s_wd;
      axi.arready = axi.arvalid && ar_c >= s_ard;
      axi.bvalid = wr_pend && b_c >= s_bd; axi.bresp = s_resp;
      axi.rvalid = rd_pend && r_c >= s_rd; axi.rdata = s_rdata; axi.rresp = s_resp;
      if (wr_pend) b_c++;
      if (rd_pend) r_c++;
      if (axi.awvalid) aw_hi++;
      if (axi.wvalid) w_hi++;
      aw_v_s = axi.awvalid; aw_a_s = axi.awaddr; aw_p_s = axi.awprot;
      w_v_s = axi.wvalid; w_d_s = axi.wdata; w_s_s = axi.wstrb;
      ar_v_s = axi.arvalid; ar_a_s = axi.araddr; ar_p_s = axi.arprot;
      b_v_s = axi.bvalid; b_r_s = axi.bready; r_v_s = axi.rvalid; r_r_s = axi.rready;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s (txn %0d): got %h want %h", name, txn, act, exp);
  endtask
  function automatic bit is_write(input logic [2:0] op);
    return op == 3'd0 || op >= 3'd6;
  endfunction
  // Reference: register select bit per opcode, node id scaled to word offsets, one cycle per handshake wait
  function automatic vec_t model(input vec_t v);
    int bits[8];
    vec_t r = v;
    bits = '{7, 7, 8, 9, 10, 15, 18, 19};
    r.e_addr = 32'h8000_0000 + 32'(v.node) * 4 + (32'd1 << bits[v.op]);
    r.e_wdata = v.op == 3'd0 ? v.wdata : v.wdata % 256;
    r.e_rdata = is_write(v.op) ? 32'd0 : v.srdata;
    r.e_resp = v.sresp;
    r.e_lat = is_write(v.op) ? (v.awd > v.wd ? v.awd : v.wd) + v.bd + 3 : v.ard + v.rd + 3;
    return r;
  endfunction
  task automatic do_txn(input vec_t v);
    int n, lat, v0;
    logic bad_rdy, bad_busy, unstable;
    logic [31:0] r0;
    logic [1:0] p0;
    txn++;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_op = v.op; cmd_node = v.node; cmd_wdata = v.wdata;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = ~v.op; cmd_node = ~v.node; cmd_wdata = ~v.wdata;
    s_awd = v.awd; s_wd = v.wd; s_bd = v.bd; s_ard = v.ard; s_rd = v.rd; s_rdata = v.srdata; s_resp = v.sresp;
    aw_hi = 0; w_hi = 0; b_n = 0; ar_n = 0; r_n = 0; v0 = viol;
    lat = 0; bad_rdy = 0; bad_busy = 0;
    do begin
      @(negedge clk); lat++;
      if (cmd_ready) bad_rdy = 1;
      if (!busy) bad_busy = 1;
    end while (!rsp_valid && lat < 100);
    #1;
    chk("latency", 32'(lat), 32'(v.e_lat));
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_resp", 32'(rsp_resp), 32'(v.e_resp));
    chk("busy_held", 32'(bad_busy), 32'd0);
    chk("cmd_ready_busy", 32'(bad_rdy), 32'd0);
    if (is_write(v.op)) begin
      chk("awaddr", got_awaddr, v.e_addr);
      chk("wdata", got_wdata, v.e_wdata);
      chk("wstrb", 32'(got_wstrb), 32'hF);
      chk("awprot", 32'(got_awprot), 32'd0);
      chk("aw_cycles", 32'(aw_hi), 32'(v.awd + 1));
      chk("w_cycles", 32'(w_hi), 32'(v.wd + 1));
      chk("b_count", 32'(b_n), 32'd1);
      chk("ar_count", 32'(ar_n), 32'd0);
    end else begin
      chk("araddr", got_araddr, v.e_addr);
      chk("arprot", 32'(got_arprot), 32'd0);
      chk("ar_count", 32'(ar_n), 32'd1);
      chk("r_count", 32'(r_n), 32'd1);
      chk("aw_cycles", 32'(aw_hi + w_hi), 32'd0);
    end
    r0 = rsp_rdata; p0 = rsp_resp; unstable = 0;
    repeat (v.hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== r0 || rsp_resp !== p0 || cmd_ready) unstable = 1;
    end
    chk("rsp_stable", 32'(unstable), 32'd0);
    rsp_ready = 1; #1;
    chk("cmd_ready_hs", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    chk("rsp_done", 32'({rsp_valid, busy, cmd_ready}), 32'b001);
    chk("protocol", 32'(viol - v0), 32'd0);
    chk("timeout_clear", 32'(timeout_flag), 32'd0);
  endtask
  initial begin
    vec_t tbl[9];
    vec_t r;
    tbl[0] = '{3'd0, 4'd3, 32'h0001_2000, 0, 0, 0, 0, 0, 32'h1111_1111, 2'b00, 0, 32'h8000_008C, 32'h0001_2000, 32'h0, 2'b00, 3};
    tbl[1] = '{3'd2, 4'd0, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0005, 2'b00, 0, 32'h8000_0100, 32'h0, 32'h0000_0005, 2'b00, 3};
    tbl[2] = '{3'd6, 4'd0, 32'hFFFF_FFA5, 4, 0, 0, 0, 0, 32'h2222_2222, 2'b00, 0, 32'h8004_0000, 32'h0000_00A5, 32'h0, 2'b00, 7};
    tbl[3] = '{3'd3, 4'd1, 32'h0, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b01, 10, 32'h8000_0204, 32'h0, 32'h1234_5678, 2'b01, 3};
    tbl[4] = '{3'd5, 4'd0, 32'h0, 0, 0, 0, 0, 0, 32'hDEAD_0001, 2'b10, 0, 32'h8000_8000, 32'h0, 32'hDEAD_0001, 2'b10, 3};
    tbl[5] = '{3'd4, 4'd0, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0042, 2'b00, 0, 32'h8000_0400, 32'h0, 32'h0000_0042, 2'b00, 3};
    tbl[6] = '{3'd7, 4'd5, 32'h1234_5633, 0, 3, 2, 0, 0, 32'h0, 2'b11, 0, 32'h8008_0014, 32'h0000_0033, 32'h0, 2'b11, 8};
    tbl[7] = '{3'd1, 4'd15, 32'h0, 0, 0, 0, 2, 1, 32'hCAFE_F00D, 2'b00, 1, 32'h8000_00BC, 32'h0, 32'hCAFE_F00D, 2'b00, 6};
    tbl[8] = '{3'd0, 4'd2, 32'hA5A5_A5A5, 2, 2, 0, 0, 0, 32'h0, 2'b10, 2, 32'h8000_0088, 32'hA5A5_A5A5, 32'h0, 2'b10, 5};
    viol = 0; b_n = 0; r_n = 0; ar_n = 0; aw_hi = 0; w_hi = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({cmd_ready, rsp_valid, busy, timeout_flag}), 32'b1000);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    chk("rst_axi", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    #1 res_n = 1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) do_txn(tbl[i]);
    for (int i = 0; i < 30; i++) begin
      r.op = 3'($urandom_range(0, 7)); r.node = 4'($urandom_range(0, 15)); r.wdata = $urandom;
      r.awd = $urandom_range(0, 4); r.wd = $urandom_range(0, 4); r.bd = $urandom_range(0, 4);
      r.ard = $urandom_range(0, 4); r.rd = $urandom_range(0, 4);
      r.srdata = $urandom; r.sresp = 2'($urandom_range(0, 3)); r.hold = $urandom_range(0, 3);
      do_txn(model(r));
    end
    txn++;
    cmd_valid = 1; cmd_op = 3'd2; cmd_node = 4'd0;
    @(posedge clk); #1;
    cmd_valid = 0; s_ard = 100000;
    repeat (16) @(negedge clk);
    chk("timeout_early", 32'({timeout_flag, axi.arvalid}), 32'b01);
    @(negedge clk);
    chk("timeout_set", 32'({timeout_flag, axi.arvalid}), 32'b11);
    repeat (8) @(negedge clk);
    chk("arvalid_held", 32'({timeout_flag, axi.arvalid, busy}), 32'b111);
    #2 res_n = 0;
    #1;
    chk("rst_async", 32'({axi.arvalid, timeout_flag, cmd_ready, busy, rsp_valid}), 32'b00100);
    chk("rst_async_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    repeat (2) @(negedge clk);
    #1 res_n = 1; s_ard = 0;
    @(negedge clk);
    do_txn(tbl[0]);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
